e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Multiply/divide unit in the execute stage; owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU with fixed multi-cycle latency, and MTHI/MTLO with single-cycle latency.
- The HI/LO values it drives are read by MFHI/MFLO in E and carried down the E/M and M/W pipeline registers to write-back.
- Its busy output feeds the hazard unit, which stalls MDU-dependent instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be at least 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be at least 1).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; the E-stage instruction is a valid, non-stalled MDU operation.
- mdu_op  input  3  operation code: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- rs_val  input  32  forwarded rs operand (multiplicand or dividend; MTHI/MTLO source).
- rt_val  input  32  forwarded rt operand (multiplier or divisor).
- busy  output  1  a multi-cycle operation is in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. At any rising edge with reset=1: hi=0, lo=0, busy=0, state=IDLE, counter=0, pending results cleared. An in-flight operation is abandoned and its results are discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; a down-counter and pending hi/lo results are held.
- IDLE with start=1:
  - MULT/MULTU: compute the 64-bit product now (signed or unsigned) and latch it as pending. Load counter=MULT_CYCLES and go to RUN.
  - DIV/DIVU: compute the quotient and remainder now and latch them as pending. Load counter=DIV_CYCLES and go to RUN.
  - MTHI: hi<=rs_val at this edge; stay in IDLE; busy stays 0.
  - MTLO: lo<=rs_val at this edge; stay in IDLE; busy stays 0.
  - NOP: no effect.
- RUN: the counter decrements each edge. On the edge where the counter reaches 0, commit the results and go to IDLE; busy falls on that same edge.
  - Multiply commit: hi<=product[63:32], lo<=product[31:0].
  - Divide commit: lo<=quotient, hi<=remainder.
- Timing: if start is sampled at edge 0, busy=1 after edges 0 through N-1. After edge N, busy=0 and the new hi/lo are visible together.
- hi/lo do not change while in RUN. MFHI/MFLO issued during RUN are stalled by the hazard unit using busy.
- start=1 while in RUN is ignored entirely, including MTHI/MTLO. The hazard unit guarantees this case never occurs; the bench checks that it has no effect.
- Signed divide:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000. There is no trap.
- Divide by zero (DIV or DIVU with rt_val=0): still busy for DIV_CYCLES cycles. On completion hi and lo keep their pre-operation values.
- Operands are captured at the start edge. Later changes on rs_val/rt_val have no effect.
- hi/lo are driven straight from registers, with no combinational path from the inputs.
- busy depends only on state; it has no combinational dependence on start.
- Stall behaviour: the hazard unit stalls an MDU-dependent instruction in D when (E-stage op is MDU-type and start) or busy. That logic lives in the hazard unit, not here.

Decomposition:
- Shared package/header mdu_defs:
  - MDU_OP encodings: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Default latency constants.
- The controller decodes instructions into these MDU_OP codes.
- One sub-module is natural: mdu_divider. It is a combinational 32-bit signed/unsigned quotient/remainder wrapper that isolates the sign handling and the divide-by-zero flag.
- The multiply uses native operators inline.

Test Plan:
- Reset then MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy=0.
- MULTU rs=0xFFFFFFFF, rt=0x00000002 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 next cycle -> hi updates after the first edge, lo after the second; busy stays 0 throughout.
- With hi=0x11, lo=0x22, issue DIV rt=0 -> busy for 10 cycles, then hi=0x11, lo=0x22 unchanged. Issue MTLO during busy -> lo unchanged.
- Start MULT, assert reset at busy cycle 3 -> next edge gives busy=0, hi=0, lo=0. Later edges commit no stale result.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encodings, FSM states and default latencies.
package e_mdu_pkg;

  // Operation codes produced by the instruction decoder.
  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  // Controller states: idle, or counting down a multi-cycle operation.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Two's-complement magnitude of a value that may be treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/e_mdu_divider.sv
// Combinational 32-bit quotient/remainder. Signed division is done on
// magnitudes and then re-signed: quotient truncates toward zero and the
// remainder follows the dividend. A zero divisor raises div_by_zero and
// the outputs are don't-care (the divisor is forced to 1 to keep them defined).
module e_mdu_divider
  import e_mdu_pkg::*;
(
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] den;
  logic [31:0] uq;
  logic [31:0] ur;

  // Magnitude-domain unsigned divide, then restore signs.
  always_comb begin
    a_neg       = signed_op & dividend[31];
    b_neg       = signed_op & divisor[31];
    a_mag       = mag32(dividend, a_neg);
    b_mag       = mag32(divisor, b_neg);
    div_by_zero = (divisor == 32'd0);
    den         = div_by_zero ? 32'd1 : b_mag;
    uq          = a_mag / den;
    ur          = a_mag % den;
    quotient    = mag32(uq, a_neg ^ b_neg);
    remainder   = mag32(ur, a_neg);
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning architectural HI/LO.
// Results are computed at the start edge and held as pending values; they
// are committed to HI/LO only when the latency counter expires, so the
// externally visible latency is fixed regardless of operand values.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      pend_hi_reg, pend_hi_next;
  logic [31:0]      pend_lo_reg, pend_lo_next;
  logic             pend_wr_reg, pend_wr_next;

  mdu_op_e     op;
  logic [63:0] prod;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_zero;

  assign op = mdu_op_e'(mdu_op);

  // 64-bit product; signed forms sign-extend both operands first.
  always_comb begin
    if (op == MDU_MULT) begin
      prod = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    end else begin
      prod = {32'd0, rs_val} * {32'd0, rt_val};
    end
  end

  e_mdu_divider u_div (
    .signed_op   (op == MDU_DIV),
    .dividend    (rs_val),
    .divisor     (rt_val),
    .quotient    (div_q),
    .remainder   (div_r),
    .div_by_zero (div_zero)
  );

  // Next-state, pending-result and HI/LO update logic.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_wr_next = pend_wr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              pend_hi_next = prod[63:32];
              pend_lo_next = prod[31:0];
              pend_wr_next = 1'b1;
              cnt_next     = CNT_W'(MULT_CYCLES);
              state_next   = ST_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              pend_hi_next = div_r;
              pend_lo_next = div_q;
              pend_wr_next = ~div_zero;
              cnt_next     = CNT_W'(DIV_CYCLES);
              state_next   = ST_RUN;
            end
            MDU_MTHI: hi_next = rs_val;
            MDU_MTLO: lo_next = rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Requests arriving here are ignored; only the countdown matters.
        if (cnt_reg == CNT_W'(1)) begin
          cnt_next     = '0;
          state_next   = ST_IDLE;
          pend_wr_next = 1'b0;
          if (pend_wr_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and architectural register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_wr_reg <= pend_wr_next;
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases followed by random operations
// compared against an arithmetic reference model of HI/LO and latency.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference semantics: HI/LO after the operation and its busy length.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa  = $signed(a);
    sb  = $signed(b);
    cyc = 0;
    case (op)
      OP_MULT: begin
        p = 64'(sa * sb);
        hi_m = p[63:32]; lo_m = p[31:0]; cyc = MC;
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        hi_m = p[63:32]; lo_m = p[31:0]; cyc = MC;
      end
      OP_DIV: begin
        if (b != 0) begin
          q = 64'(sa / sb); r = 64'(sa % sb);
          lo_m = q[31:0]; hi_m = r[31:0];
        end
        cyc = DC;
      end
      OP_DIVU: begin
        if (b != 0) begin
          lo_m = a / b; hi_m = a % b;
        end
        cyc = DC;
      end
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  // Issue one op, count busy cycles, optionally poke an MTHI/MTLO mid-run.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit intrude);
    int          cyc, cycles;
    logic [31:0] hi_pre, lo_pre;
    hi_pre = hi_m;
    lo_pre = lo_m;
    model_op(op, a, b, cyc);
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; mdu_op = OP_NOP; rs_val = $urandom; rt_val = $urandom;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      check({name, "_hold_hi"}, hi, hi_pre);
      check({name, "_hold_lo"}, lo, lo_pre);
      cycles++;
      if (intrude && cycles == 2) begin
        start  = 1'b1;
        mdu_op = ($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO;
        rs_val = $urandom;
      end else begin
        start  = 1'b0;
        mdu_op = OP_NOP;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mdu_op = OP_NOP;
    check({name, "_busy_len"}, 32'(cycles), 32'(cyc));
    check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({name, "_hi"}, hi, hi_m);
    check({name, "_lo"}, lo, lo_m);
    $display("[TB] %s op=%0d rs=%h rt=%h busy=%0d hi=%h lo=%h", name, op, a, b, cycles, hi, lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = OP_NOP; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // Directed arithmetic cases.
    do_op("mult_neg",   OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("mult_neg_hi_lit", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo_lit", lo, 32'hFFFF_FFFE);
    do_op("multu",      OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("multu_hi_lit", hi, 32'h0000_0001);
    do_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo_lit", lo, 32'hFFFF_FFFD);
    check("div_neg_hi_lit", hi, 32'hFFFF_FFFF);
    do_op("divu",       OP_DIVU,  32'd7, 32'd2, 1'b0);
    check("divu_lo_lit", lo, 32'd3);
    do_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo_lit", lo, 32'h8000_0000);
    do_op("div_pos_neg", OP_DIV,  32'd7, 32'hFFFF_FFFE, 1'b0);

    // Back-to-back MTHI then MTLO.
    @(negedge clk);
    start = 1'b1; mdu_op = OP_MTHI; rs_val = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo_keep", lo, lo_m);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; mdu_op = OP_MTLO; rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; mdu_op = OP_NOP;
    hi_m = 32'h1234_5678; lo_m = 32'h9ABC_DEF0;
    check("mtlo_lo", lo, lo_m);
    check("mtlo_hi_keep", hi, hi_m);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // Divide by zero keeps HI/LO; MTLO during busy ignored.
    do_op("set_hi", OP_MTHI, 32'h11, 32'd0, 1'b0);
    do_op("set_lo", OP_MTLO, 32'h22, 32'd0, 1'b0);
    do_op("div0",   OP_DIV,  32'd1234, 32'd0, 1'b1);
    check("div0_hi_lit", hi, 32'h11);
    check("div0_lo_lit", lo, 32'h22);
    do_op("divu0",  OP_DIVU, 32'hDEAD_BEEF, 32'd0, 1'b1);

    // Reset during a multiply abandons it.
    @(negedge clk);
    start = 1'b1; mdu_op = OP_MULT; rs_val = 32'h0000_1234; rt_val = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0; mdu_op = OP_NOP;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    check("midrst_stale_hi", hi, 32'd0);
    check("midrst_stale_lo", lo, 32'd0);
    check("midrst_stale_busy", {31'd0, busy}, 32'd0);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 6));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      do_op("rand", op, a, b, ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
